// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store unit in front of the data RAM.
//   lsu_state_e : FSM states (IDLE, ACCESS, RESP)
//   lsu_size_e  : access width decoded from funct3[1:0]
//   F3_*        : RV32I load/store funct3 encodings
//   size_of()   : funct3 -> access width
//   f3_legal()  : funct3 legality for a load or a store
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Width comes from the low two bits; the unsigned variants share them.
    function automatic lsu_size_e size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd0:    return SZ_B;
            2'd1:    return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    // Stores only have signed-looking encodings; loads add BU/HU.
    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_mem_if_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane steering for the load/store unit.
//   funct3_i, offset_i : latched access type and addr[1:0] (store/load paths)
//   wdata_i  -> wdata_o: store data replicated across lanes
//   wstrb_o            : byte strobes for the store
//   rdata_i  -> rdata_o: RAM word -> selected, extended load data
//   chk_funct3_i, chk_offset_i -> misaligned_o : alignment check on the
//                        incoming request (evaluated before it is latched)
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] rdata_o,
    input  logic [2:0]  chk_funct3_i,
    input  logic [1:0]  chk_offset_i,
    output logic        misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: replicate so the RAM can take any lane without a shifter.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        wdata_o = wdata_i;
        wstrb_o = 4'b1111;
        case (size_of(funct3_i))
            SZ_B: begin
                wdata_o = {4{wdata_i[7:0]}};
                wstrb_o = 4'b0001 << offset_i;
            end
            SZ_H: begin
                wdata_o = {2{wdata_i[15:0]}};
                wstrb_o = offset_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Load side: pick the lane, then extend according to funct3.
    assign byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    assign half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        rdata_o = rdata_i;
        case (funct3_i)
            F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_o = {24'd0, byte_sel};
            F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_o = {16'd0, half_sel};
            default: ;
        endcase
    end

    always_comb begin
        misaligned_o = 1'b0;
        case (size_of(chk_funct3_i))
            SZ_B:    misaligned_o = 1'b0;
            SZ_H:    misaligned_o = chk_offset_i[0];
            default: misaligned_o = |chk_offset_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_if
// Load/store unit between the core's MEM stage and the data RAM.
// Three-state FSM: IDLE (accept) -> ACCESS (one RAM cycle) -> RESP.
//   clk, reset            : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_we, req_funct3, req_addr, req_wdata : request payload
//   resp_valid/resp_ready : response handshake
//   resp_rdata, resp_err  : extended load data (0 on store/fault), fault flag
//   ram_we, ram_addr, ram_wdata, ram_wstrb, ram_st_misaligned : RAM controls
//   ram_rdata             : RAM read data (combinational read)
// Parameters: RAM_BYTES (addresses at or above fault), RESP_HOLD (1: hold
// resp_valid until resp_ready; 0: single-cycle pulse).
// Optional macro LSU_BADADDR_EN adds output badaddr, loaded with the address
// of every faulting request and reset to 0.
// -----------------------------------------------------------------------------
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int unsigned RAM_BYTES = 256,
    parameter bit          RESP_HOLD = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wstrb,
    output logic        ram_st_misaligned,
`ifdef LSU_BADADDR_EN
    output logic [31:0] badaddr,
`endif
    input  logic [31:0] ram_rdata
);

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        fault_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic        req_misaligned;
    logic        req_fault;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_data;

    assign accept = (state_q == IDLE) && req_valid;

    lsu_align u_align (
        .funct3_i     (funct3_q),
        .offset_i     (addr_q[1:0]),
        .wdata_i      (wdata_q),
        .rdata_i      (ram_rdata),
        .wdata_o      (st_wdata),
        .wstrb_o      (st_wstrb),
        .rdata_o      (ld_data),
        .chk_funct3_i (req_funct3),
        .chk_offset_i (req_addr[1:0]),
        .misaligned_o (req_misaligned)
    );

    // Fault is decided on the raw request so it is ready at the accept edge.
    assign req_fault = !f3_legal(req_we, req_funct3) || req_misaligned ||
                       (req_addr >= RAM_BYTES);

    // ------------------------------------------------------------------ FSM
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (!RESP_HOLD || resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            fault_q      <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                fault_q  <= req_fault;
            end
            // The load word is sampled on the same edge the RAM commits a store.
            if (state_q == ACCESS) begin
                resp_rdata_q <= (we_q || fault_q) ? 32'd0 : ld_data;
                resp_err_q   <= fault_q;
            end
        end
    end

`ifdef LSU_BADADDR_EN
    logic [31:0] badaddr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            badaddr_q <= 32'd0;
        end else if (accept && req_fault) begin
            badaddr_q <= req_addr;
        end
    end

    assign badaddr = badaddr_q;
`endif

    // -------------------------------------------------------------- outputs
    // RAM strobes are decoded from state_q, so a reset mid-ACCESS drops
    // ram_we immediately and the pending store never reaches the RAM.
    assign ram_we            = (state_q == ACCESS) && we_q && !fault_q;
    assign ram_st_misaligned = (state_q == ACCESS) && we_q && fault_q;
    assign ram_wstrb         = ram_we ? st_wstrb : 4'b0000;
    assign ram_addr          = addr_q;
    assign ram_wdata         = st_wdata;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
